// File: rtl/avmm_resp_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
// LFSR constants are only consumed when AVMM_RESP_STALL_INJECT_EN is defined.
package avmm_resp_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/resp_lfsr16.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random waitrequest stalls.
// Present only when AVMM_RESP_STALL_INJECT_EN is defined.
`ifdef AVMM_RESP_STALL_INJECT_EN
module resp_lfsr16
  import avmm_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule
`endif

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory with fixed pipelined read latency and waitrequest backpressure.
// Define AVMM_RESP_STALL_INJECT_EN to add LFSR-driven random stall cycles.
module avmm_mem_responder
  import avmm_resp_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        proto_err
);

  localparam int         DEPTH    = 2 ** MEM_AW;
  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

  logic [31:0]       mem [DEPTH];
  logic              vld_p [READ_LATENCY];
  logic [31:0]       data_p [READ_LATENCY];
  logic [31:0]       last_data;
  logic [3:0]        pending;
  logic              init_done;
  logic              stall;
  logic              req_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic [MEM_AW-1:0] idx;
  logic              unused_addr;
  rd_pipe_t          rsp;

`ifdef AVMM_RESP_STALL_INJECT_EN
  logic [15:0] lfsr;

  resp_lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (init_done),
    .lfsr (lfsr)
  );

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign idx         = slave_address[MEM_AW-1:0];
  assign unused_addr = ^slave_address[31:MEM_AW];

  // Waitrequest depends on registered state only, never on the request inputs
  assign slave_waitrequest = !init_done | (pending == PEND_MAX) | stall;
  assign req_ok            = !slave_waitrequest & rst_n;
  assign wr_acc            = slave_write & req_ok;
  // A simultaneous read and write performs only the write
  assign rd_acc            = slave_read & !slave_write & req_ok;

  assign rsp                 = '{valid: vld_p[READ_LATENCY-1], data: data_p[READ_LATENCY-1]};
  assign slave_readdatavalid = rsp.valid;
  assign slave_readdata      = rsp.valid ? rsp.data : last_data;

  // Stage p0: RAM access; p1..pN: latency shift towards the response port
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= slave_writedata;
    end
    data_p[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      pending   <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
      last_data <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      init_done <= 1'b1;
      vld_p[0]  <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      if (rd_acc && !rsp.valid) begin
        pending <= pending + 4'd1;
      end else if (!rd_acc && rsp.valid) begin
        pending <= pending - 4'd1;
      end
      if (rd_acc) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wr_acc) begin
        wr_count <= wr_count + 32'd1;
      end
      if (slave_read && slave_write && req_ok) begin
        proto_err <= 1'b1;
      end
      if (rsp.valid) begin
        last_data <= rsp.data;
      end
    end
  end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: two instances (latency 2 and latency 8) checked every
// cycle against a transaction-level model of acceptance, outstanding reads and return times.
module tb_avmm_mem_responder;

  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int RL0    = 2;
  localparam int RL1    = 8;
  localparam int MP0    = 4;
  localparam int MP1    = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       rd    = '0;
  logic [1:0]       wr    = '0;
  logic [1:0][31:0] addr  = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       wq;
  logic [1:0]       rdv;
  logic [1:0]       perr;
  logic [1:0][31:0] rdata;
  logic [1:0][31:0] rdc;
  logic [1:0][31:0] wrc;

  int nvec    = 0;
  int nerr    = 0;
  int npulse1 = 0;
  int k       = 0;

  always #5 clk = ~clk;

  avmm_mem_responder #(.MEM_AW(MEM_AW), .READ_LATENCY(RL0), .MAX_PENDING(MP0)) u_dut0 (
    .clk                (clk),
    .rst_n              (rst_n),
    .slave_waitrequest  (wq[0]),
    .slave_address      (addr[0]),
    .slave_read         (rd[0]),
    .slave_readdata     (rdata[0]),
    .slave_readdatavalid(rdv[0]),
    .slave_write        (wr[0]),
    .slave_writedata    (wdata[0]),
    .rd_count           (rdc[0]),
    .wr_count           (wrc[0]),
    .proto_err          (perr[0])
  );

  avmm_mem_responder #(.MEM_AW(MEM_AW), .READ_LATENCY(RL1), .MAX_PENDING(MP1)) u_dut1 (
    .clk                (clk),
    .rst_n              (rst_n),
    .slave_waitrequest  (wq[1]),
    .slave_address      (addr[1]),
    .slave_read         (rd[1]),
    .slave_readdata     (rdata[1]),
    .slave_readdatavalid(rdv[1]),
    .slave_write        (wr[1]),
    .slave_writedata    (wdata[1]),
    .rd_count           (rdc[1]),
    .wr_count           (wrc[1]),
    .proto_err          (perr[1])
  );

  // Reference model: memory image, outstanding reads with the edge at which they retire
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq    [2][$];
  logic [31:0] mm    [2][DEPTH];
  bit          minit [2];
  logic [31:0] mrdc  [2];
  logic [31:0] mwrc  [2];
  logic [31:0] mlast [2];
  logic [31:0] exp_d [2];
  logic        mperr [2];
  logic        exp_v [2];
  logic        exp_w [2];

  function automatic int rl_of(input int i);
    return (i == 0) ? RL0 : RL1;
  endfunction

  function automatic int mp_of(input int i);
    return (i == 0) ? MP0 : MP1;
  endfunction

  task automatic model_edge(input int i);
    rsp_t              e;
    bit                busy;
    logic [MEM_AW-1:0] a;
    a = addr[i][MEM_AW-1:0];
    if (!rst_n) begin
      minit[i] = 1'b0;
      rq[i].delete();
      mrdc[i]  = '0;
      mwrc[i]  = '0;
      mperr[i] = 1'b0;
      mlast[i] = '0;
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end else begin
      busy = !minit[i] || (rq[i].size() == mp_of(i));
      if (!busy && wr[i]) begin
        mm[i][a] = wdata[i];
        mwrc[i]  = mwrc[i] + 32'd1;
      end
      if (!busy && wr[i] && rd[i]) mperr[i] = 1'b1;
      if (!busy && rd[i] && !wr[i]) begin
        e.due  = k + rl_of(i);
        e.data = mm[i][a];
        rq[i].push_back(e);
        mrdc[i] = mrdc[i] + 32'd1;
      end
      minit[i] = 1'b1;
      while (rq[i].size() > 0 && rq[i][0].due <= k) void'(rq[i].pop_front());
      exp_v[i] = (rq[i].size() > 0) && (rq[i][0].due == k + 1);
      if (exp_v[i]) mlast[i] = rq[i][0].data;
      exp_d[i] = mlast[i];
    end
    exp_w[i] = !minit[i] || (rq[i].size() == mp_of(i));
  endtask

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, i, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    k++;
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("waitrequest", i, 32'(wq[i]), 32'(exp_w[i]));
      check("readdatavalid", i, 32'(rdv[i]), 32'(exp_v[i]));
      check("readdata", i, rdata[i], exp_d[i]);
      check("rd_count", i, rdc[i], mrdc[i]);
      check("wr_count", i, wrc[i], mwrc[i]);
      check("proto_err", i, 32'(perr[i]), 32'(mperr[i]));
    end
  end

  always @(posedge clk) begin
    #2;
    if (rdv[1]) npulse1++;
  end

  // Called at a negedge; returns at the negedge following the accepting posedge
  task automatic req(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit acc = 1'b0;
    int n   = 0;
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    while (!acc && n < 200) begin
      acc = !wq[i];
      @(negedge clk);
      n++;
    end
    nvec++;
    assert (acc) else begin
      nerr++;
      $error("FAIL accept[%0d] observed no accept expected accept within 200 cycles", i);
    end
  endtask

  task automatic idle();
    rd = '0;
    wr = '0;
  endtask

  task automatic expect_return(input int i, input int lat, input logic [31:0] d);
    int n = 1;
    while (!rdv[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", i, 32'(n), 32'(lat));
    check("return_data", i, rdata[i], d);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("wait_first_cycle", 0, 32'(wq), 32'd3);
    @(negedge clk);
    check("wait_after_init", 0, 32'(wq), 32'd0);
    check("rdv_after_init", 0, 32'(rdv), 32'd0);

    // Preload RAM[a] = a*3 in both instances
    for (int a = 0; a < DEPTH; a++) begin
      wr       = 2'b11;
      addr[0]  = 32'(a);
      addr[1]  = 32'(a);
      wdata[0] = 32'(a * 3);
      wdata[1] = 32'(a * 3);
      @(negedge clk);
    end
    idle();

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 8; a++) req(0, 1'b1, 1'b0, 32'(a), 32'd0);
    idle();
    repeat (6) @(negedge clk);
    check("rd_count_8", 0, rdc[0], 32'd8);
    check("wr_count_0", 0, wrc[0], 32'd0);

    req(0, 1'b0, 1'b1, 32'd5, 32'h0001_8000);
    req(0, 1'b1, 1'b0, 32'd5, 32'd0);
    idle();
    expect_return(0, RL0, 32'h0001_8000);

    n0 = npulse1;
    for (int j = 0; j < 4; j++) req(1, 1'b1, 1'b0, 32'(16 + j), 32'd0);
    check("wait_full", 1, 32'(wq[1]), 32'd1);
    for (int j = 4; j < 6; j++) req(1, 1'b1, 1'b0, 32'(16 + j), 32'd0);
    idle();
    repeat (20) @(negedge clk);
    check("rd_count_6", 1, rdc[1], 32'd6);
    check("returned_6", 1, 32'(npulse1 - n0), 32'd6);

    req(0, 1'b0, 1'b1, 32'(DEPTH + 2), 32'hDEAD_BEEF);
    req(0, 1'b1, 1'b0, 32'd2, 32'd0);
    idle();
    expect_return(0, RL0, 32'hDEAD_BEEF);

    req(0, 1'b1, 1'b1, 32'd9, 32'd7);
    idle();
    @(negedge clk);
    check("proto_err_set", 0, 32'(perr[0]), 32'd1);
    req(0, 1'b1, 1'b0, 32'd9, 32'd0);
    idle();
    expect_return(0, RL0, 32'd7);

    req(1, 1'b1, 1'b0, 32'd3, 32'd0);
    req(1, 1'b1, 1'b0, 32'd4, 32'd0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = npulse1;
    repeat (12) @(negedge clk);
    check("no_valid_after_reset", 1, 32'(npulse1 - n0), 32'd0);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        rd[i]    = 1'($urandom_range(0, 1));
        wr[i]    = ($urandom_range(0, 7) == 0);
        addr[i]  = 32'($urandom_range(0, 2 * DEPTH - 1));
        wdata[i] = $urandom;
      end
      @(negedge clk);
    end
    idle();
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
